hazard_ctrl_mc: RTL and testbench
=================================

# hazard_ctrl_mc

Multi-cycle hazard controller for the cached five-stage RISC-V pipeline. It handles three hazards:
- load-use hazards, with a configurable number of bubbles;
- whole-pipeline freezes while the data cache services a miss, with a watchdog timeout;
- taken-branch flushes.

It sits beside the pipeline registers and drives their enable and synchronous-clear inputs. It also keeps a saturating stall-cycle counter for performance measurement.

## Interface
Parameters:
- REG_AW, default 5: register address width.
- LOAD_BUBBLES, default 1: bubbles inserted per load-use hazard. Legal range 1..3.
- TIMEOUT, default 64: number of cycles in MISS before TimeoutErr is raised. Must be ≥ 2.
- CNT_W, default 16: StallCount width.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- ResultSrcE  in  2  result select of the instruction in E. The value 2'b01 marks a load.
- RdE  in  REG_AW  destination register in E.
- Rs1D, Rs2D  in  REG_AW  source registers in D.
- PCSrcE  in  1  taken branch/jump resolved in E.
- MissM  in  1  data cache reports a miss for the access in M. Pulse or level.
- ReadyM  in  1  cache fill complete; M data valid this cycle.
- FEN, DEN, EEN, MEN  out  1 each  enables for the PC/IF-ID, ID-EX, EX-MEM and MEM-WB registers. 1 = advance.
- RSTD, RSTE  out  1 each  synchronous clears for the IF-ID and ID-EX registers. 1 = insert bubble.
- Busy  out  1  high when any stall is in force this cycle.
- TimeoutErr  out  1  sticky; set when a miss exceeds TIMEOUT cycles.
- StallCount  out  CNT_W  number of cycles with FEN=0, saturating.

## Operation
- State: FSM {IDLE, MISS}. Bubble counter bcnt is 2 bits. Watchdog counter wcnt is ⌈log2(TIMEOUT+1)⌉ bits.
- Default outputs: all enables 1, RSTD=RSTE=0.
- **Load-use detect (LU):**
  - Condition: ResultSrcE==2'b01, RdE≠0, and (Rs1D==RdE or Rs2D==RdE).
  - Register x0 never causes a hazard.
- **Miss freeze:**
  - Trigger: state IDLE and MissM=1. In that cycle FEN=DEN=EEN=MEN=0, and next state is MISS.
  - In MISS with ReadyM=0, all four enables stay 0 and wcnt increments.
  - In MISS with ReadyM=1, all enables are 1 (release in the same cycle), next state is IDLE, and wcnt is cleared.
  - During a freeze, RSTD=RSTE=0. PCSrcE and LU are ignored because the E contents are held.
  - When wcnt reaches TIMEOUT-1 while still in MISS, TimeoutErr is set. It clears only on rst. The freeze continues regardless.
- **Load-use stall:** applies only when not in a miss freeze.
  - If bcnt==0 and LU: FEN=DEN=0 and RSTE=1, and bcnt loads LOAD_BUBBLES-1.
  - If bcnt>0: FEN=DEN=0 and RSTE=1, and bcnt decrements. The consumer stays in D until the load value reaches the forwarding point.
- **Branch flush:** applies only when not frozen.
  - PCSrcE=1 gives RSTD=1 and RSTE=1.
  - It also clears bcnt to 0 and overrides the load-use stall that cycle, so FEN=DEN=1.
- **Priority:** miss freeze > branch flush > load-use / bubble countdown.
  - A pending bcnt is frozen (neither decremented nor cleared) while the pipeline is in a miss freeze.
- **Busy** = (any enable is 0) or RSTE caused by the load-use path.
- **StallCount** increments on every cycle with FEN=0 and holds at 2^CNT_W−1.

## Timing
- Enables and clears are combinational from the current inputs and registered state. They are valid in the same cycle, with no added latency.
- The FSM, bcnt, wcnt, TimeoutErr and StallCount update on the rising edge of clk.
- **Reset values** (while rst=1 and after it): state IDLE, bcnt=0, wcnt=0, TimeoutErr=0, StallCount=0.
  - While rst=1, outputs are forced to FEN=DEN=EEN=MEN=1, RSTD=RSTE=0, Busy=0.
  - Reset asserted mid-miss or mid-countdown abandons it immediately.
- **Miss timing:**
  - A miss pulse of one cycle followed by ReadyM N cycles later freezes the pipeline for exactly N+1 cycles. The release cycle, in which ReadyM=1, is not a frozen cycle.
  - ReadyM in the same cycle as MissM while in IDLE: the cycle is frozen, the FSM enters MISS, and ReadyM is ignored in that cycle.
  - MissM in MISS is ignored.
  - MissM in the release cycle is ignored; a new miss is detected on the following cycle.
- **Load-use timing:** an LU hazard stalls F/D for exactly LOAD_BUBBLES cycles, provided no intervening miss or flush occurs.

## Test plan
1. **Basic load-use:** LOAD_BUBBLES=1, ResultSrcE=01, RdE=5, Rs2D=5 for one cycle → FEN=DEN=0 and RSTE=1 for exactly 1 cycle; StallCount=1.
2. **Deeper bubbles and x0:** LOAD_BUBBLES=3, RdE=7, Rs1D=7 → 3 consecutive stall cycles, then FEN=1. Repeat with RdE=0, Rs1D=0 → no stall.
3. **Miss freeze:** MissM pulse, ReadyM asserted 4 cycles later → all enables 0 for 5 cycles and 1 on the ReadyM cycle; TimeoutErr=0; StallCount=5.
4. **Watchdog:** TIMEOUT=8, MissM with ReadyM held low for 20 cycles → TimeoutErr rises on the 8th MISS cycle and stays set after ReadyM; only rst clears it.
5. **Priority and interaction:**
   - LU and MissM in the same cycle → freeze only (RSTE=0); LU stall is applied after release.
   - PCSrcE=1 during an LOAD_BUBBLES=3 countdown → RSTD=RSTE=1 and FEN=1; bcnt is cleared.
6. **Reset and saturation:**
   - rst asserted in the 2nd MISS cycle → next cycle state is IDLE and all enables are 1.
   - CNT_W=4 with continuous stalls → StallCount holds at 15.

Source files
------------

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc
// ------------------------------------------------------------------------
// Multi-cycle hazard controller for the cached five-stage RISC-V pipeline.
// It drives the enable and synchronous-clear inputs of the pipeline
// registers, and it resolves three hazards:
//   - load-use hazards, by inserting LOAD_BUBBLES bubbles;
//   - data-cache misses, by freezing the whole pipeline until the fill
//     completes, with a watchdog that flags overly long misses;
//   - taken branches, by flushing the D and E stages.
// It also keeps a saturating count of front-end stall cycles.
//
// Parameters
//   REG_AW       register address width
//   LOAD_BUBBLES bubbles per load-use hazard (1..3)
//   TIMEOUT      MISS cycles before o_TimeoutErr is raised (>= 2)
//   CNT_W        width of o_StallCount
//
// Ports
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_ResultSrcE          result select in E (2'b01 = load)
//   i_RdE                 destination register in E
//   i_Rs1D, i_Rs2D        source registers in D
//   i_PCSrcE              taken branch/jump resolved in E
//   i_MissM, i_ReadyM     data-cache miss report / fill complete
//   o_FEN, o_DEN          PC/IF-ID and ID-EX enables (1 = advance)
//   o_EEN, o_MEN          EX-MEM and MEM-WB enables (1 = advance)
//   o_RSTD, o_RSTE        IF-ID and ID-EX clears (1 = insert bubble)
//   o_Busy                some stall is in force this cycle
//   o_TimeoutErr          sticky watchdog flag, cleared only by reset
//   o_StallCount          saturating count of cycles with o_FEN = 0
// ------------------------------------------------------------------------
module hazard_ctrl_mc #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int TIMEOUT      = 64,
    parameter int CNT_W        = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [1:0]        i_ResultSrcE,
    input  logic [REG_AW-1:0] i_RdE,
    input  logic [REG_AW-1:0] i_Rs1D,
    input  logic [REG_AW-1:0] i_Rs2D,
    input  logic              i_PCSrcE,
    input  logic              i_MissM,
    input  logic              i_ReadyM,
    output logic              o_FEN,
    output logic              o_DEN,
    output logic              o_EEN,
    output logic              o_MEN,
    output logic              o_RSTD,
    output logic              o_RSTE,
    output logic              o_Busy,
    output logic              o_TimeoutErr,
    output logic [CNT_W-1:0]  o_StallCount
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    // The watchdog flag is set on the edge where wcnt steps onto
    // TIMEOUT-1, so it is visible during the TIMEOUT-th MISS cycle.
    localparam logic [WCNT_W-1:0] WCNT_ARM  = WCNT_W'(TIMEOUT - 2);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(TIMEOUT);
    localparam logic [1:0]        BCNT_LOAD = 2'(LOAD_BUBBLES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_MISS
    } state_t;

    state_t            r_state;
    logic [1:0]        r_bcnt;
    logic [WCNT_W-1:0] r_wcnt;
    logic              r_timeoutErr;
    logic [CNT_W-1:0]  r_stallCount;

    logic w_loadUse;
    logic w_freeze;
    logic w_flush;
    logic w_luStall;

    assign w_loadUse = (i_ResultSrcE == 2'b01) && (i_RdE != '0) &&
                       ((i_Rs1D == i_RdE) || (i_Rs2D == i_RdE));

    // A miss freezes the cycle it is first seen in IDLE; once in MISS the
    // freeze lasts until the fill completes, and the ReadyM cycle itself
    // already runs normally.
    assign w_freeze  = (r_state == ST_IDLE) ? i_MissM : !i_ReadyM;

    assign w_flush   = !w_freeze && i_PCSrcE;

    // A pending bubble count keeps stalling even after the load has left
    // E, because the consumer is still waiting in D.
    assign w_luStall = !w_freeze && !i_PCSrcE &&
                       ((r_bcnt != 2'd0) || w_loadUse);

    always_comb begin
        o_FEN  = 1'b1;
        o_DEN  = 1'b1;
        o_EEN  = 1'b1;
        o_MEN  = 1'b1;
        o_RSTD = 1'b0;
        o_RSTE = 1'b0;
        o_Busy = 1'b0;
        if (!i_rst) begin
            if (w_freeze) begin
                o_FEN  = 1'b0;
                o_DEN  = 1'b0;
                o_EEN  = 1'b0;
                o_MEN  = 1'b0;
                o_Busy = 1'b1;
            end else if (w_flush) begin
                o_RSTD = 1'b1;
                o_RSTE = 1'b1;
            end else if (w_luStall) begin
                o_FEN  = 1'b0;
                o_DEN  = 1'b0;
                o_RSTE = 1'b1;
                o_Busy = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= 2'd0;
            r_wcnt       <= '0;
            r_timeoutErr <= 1'b0;
            r_stallCount <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_MissM) begin
                        r_state <= ST_MISS;
                        r_wcnt  <= '0;
                    end
                end
                ST_MISS: begin
                    if (i_ReadyM) begin
                        r_state <= ST_IDLE;
                        r_wcnt  <= '0;
                    end else begin
                        if (r_wcnt != WCNT_MAX) begin
                            r_wcnt <= r_wcnt + 1'b1;
                        end
                        if (r_wcnt >= WCNT_ARM) begin
                            r_timeoutErr <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // During a freeze neither branch is taken, so bcnt holds.
            if (w_flush) begin
                r_bcnt <= 2'd0;
            end else if (w_luStall) begin
                r_bcnt <= (r_bcnt != 2'd0) ? (r_bcnt - 2'd1) : BCNT_LOAD;
            end

            if (!o_FEN && !(&r_stallCount)) begin
                r_stallCount <= r_stallCount + 1'b1;
            end
        end
    end

    assign o_TimeoutErr = r_timeoutErr;
    assign o_StallCount = r_stallCount;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc
// ------------------------------------------------------------------------
// Drives two controllers from the same input stream:
//   dut0: LOAD_BUBBLES=1, TIMEOUT=8,  CNT_W=4
//   dut1: LOAD_BUBBLES=3, TIMEOUT=64, CNT_W=16
// A behavioural model predicts every output of both instances on every
// cycle, and hand-computed literal expectations pin key points.
// ------------------------------------------------------------------------
module tb_hazard_ctrl_mc;

    localparam int LB0 = 1;
    localparam int LB1 = 3;
    localparam int TO0 = 8;
    localparam int TO1 = 64;
    localparam int CW0 = 4;
    localparam int CW1 = 16;

    logic        clk;
    logic        rst;
    logic [1:0]  resultSrcE;
    logic [4:0]  rdE;
    logic [4:0]  rs1D;
    logic [4:0]  rs2D;
    logic        pcSrcE;
    logic        missM;
    logic        readyM;

    logic [1:0]  fen;
    logic [1:0]  den;
    logic [1:0]  een;
    logic [1:0]  men;
    logic [1:0]  rstd;
    logic [1:0]  rste;
    logic [1:0]  busy;
    logic [1:0]  terr;
    logic [3:0]  scA;
    logic [15:0] scB;

    int  nChecks = 0;
    int  nFail   = 0;
    bit  checkEn = 1'b0;

    // Model state, kept as plain integers per instance.
    int  mInMiss [2];
    int  mAge    [2];
    int  mBub    [2];
    int  mErr    [2];
    int  mCnt    [2];

    hazard_ctrl_mc #(
        .REG_AW(5), .LOAD_BUBBLES(LB0), .TIMEOUT(TO0), .CNT_W(CW0)
    ) dut0 (
        .i_clk(clk), .i_rst(rst), .i_ResultSrcE(resultSrcE), .i_RdE(rdE),
        .i_Rs1D(rs1D), .i_Rs2D(rs2D), .i_PCSrcE(pcSrcE), .i_MissM(missM),
        .i_ReadyM(readyM), .o_FEN(fen[0]), .o_DEN(den[0]), .o_EEN(een[0]),
        .o_MEN(men[0]), .o_RSTD(rstd[0]), .o_RSTE(rste[0]), .o_Busy(busy[0]),
        .o_TimeoutErr(terr[0]), .o_StallCount(scA)
    );

    hazard_ctrl_mc #(
        .REG_AW(5), .LOAD_BUBBLES(LB1), .TIMEOUT(TO1), .CNT_W(CW1)
    ) dut1 (
        .i_clk(clk), .i_rst(rst), .i_ResultSrcE(resultSrcE), .i_RdE(rdE),
        .i_Rs1D(rs1D), .i_Rs2D(rs2D), .i_PCSrcE(pcSrcE), .i_MissM(missM),
        .i_ReadyM(readyM), .o_FEN(fen[1]), .o_DEN(den[1]), .o_EEN(een[1]),
        .o_MEN(men[1]), .o_RSTD(rstd[1]), .o_RSTE(rste[1]), .o_Busy(busy[1]),
        .o_TimeoutErr(terr[1]), .o_StallCount(scB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit isLoadUse();
        return (resultSrcE == 2'b01) && (rdE != 5'd0) &&
               ((rs1D == rdE) || (rs2D == rdE));
    endfunction

    function automatic bit isFrozen(input int k);
        if (rst) return 1'b0;
        return (mInMiss[k] != 0) ? !readyM : missM;
    endfunction

    // Expected {FEN,DEN,EEN,MEN,RSTD,RSTE,Busy,TimeoutErr} for instance k.
    function automatic logic [7:0] expFlags(input int k);
        logic [7:0] f;
        f = {4'b1111, 3'b000, (mErr[k] != 0)};
        if (!rst) begin
            if (isFrozen(k)) begin
                f[7:4] = 4'b0000;
                f[1]   = 1'b1;
            end else if (pcSrcE) begin
                f[3] = 1'b1;
                f[2] = 1'b1;
            end else if (mBub[k] > 0 || isLoadUse()) begin
                f[7] = 1'b0;
                f[6] = 1'b0;
                f[2] = 1'b1;
                f[1] = 1'b1;
            end
        end
        return f;
    endfunction

    function automatic logic [7:0] dutFlags(input int k);
        return {fen[k], den[k], een[k], men[k], rstd[k], rste[k], busy[k], terr[k]};
    endfunction

    function automatic int dutCount(input int k);
        return (k == 0) ? int'(scA) : int'(scB);
    endfunction

    // Advance the model at each rising edge using the inputs of the
    // cycle that is ending.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [7:0] f;
            bit         frz;
            int         cntMax;
            f      = expFlags(k);
            frz    = isFrozen(k);
            cntMax = (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
            if (rst) begin
                mInMiss[k] = 0;
                mAge[k]    = 0;
                mBub[k]    = 0;
                mErr[k]    = 0;
                mCnt[k]    = 0;
            end else begin
                if (!frz) begin
                    if (pcSrcE)                mBub[k] = 0;
                    else if (mBub[k] > 0)      mBub[k] = mBub[k] - 1;
                    else if (isLoadUse())      mBub[k] = ((k == 0) ? LB0 : LB1) - 1;
                end
                if (mInMiss[k] == 0) begin
                    if (missM) begin
                        mInMiss[k] = 1;
                        mAge[k]    = 0;
                    end
                end else if (readyM) begin
                    mInMiss[k] = 0;
                    mAge[k]    = 0;
                end else begin
                    mAge[k] = mAge[k] + 1;
                    if (mAge[k] >= ((k == 0) ? TO0 : TO1) - 1) mErr[k] = 1;
                end
                if (f[7] == 1'b0 && mCnt[k] < cntMax) mCnt[k] = mCnt[k] + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checkEn) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("flags{F,D,E,M,RSTD,RSTE,Busy,TErr} dut%0d", k),
                            int'(dutFlags(k)), int'(expFlags(k)));
                checkOutput($sformatf("StallCount dut%0d", k), dutCount(k), mCnt[k]);
            end
        end
    end

    task automatic applyStimulus(input logic r, input logic [1:0] rs, input logic [4:0] rd,
                                 input logic [4:0] r1, input logic [4:0] r2,
                                 input logic pc, input logic ms, input logic rdy);
        @(posedge clk);
        #1;
        rst        = r;
        resultSrcE = rs;
        rdE        = rd;
        rs1D       = r1;
        rs2D       = r2;
        pcSrcE     = pc;
        missM      = ms;
        readyM     = rdy;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            mInMiss[k] = 0; mAge[k] = 0; mBub[k] = 0; mErr[k] = 0; mCnt[k] = 0;
        end
        rst = 1'b1; resultSrcE = 2'b00; rdE = 0; rs1D = 0; rs2D = 0;
        pcSrcE = 0; missM = 0; readyM = 0;

        // Reset
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0);
        checkEn = 1'b1;
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("lit reset FEN dut0", int'(fen[0]), 1);
        checkOutput("lit reset Busy dut0", int'(busy[0]), 0);
        checkOutput("lit reset StallCount dut0", int'(scA), 0);

        // Basic load-use: RdE=5 matched by Rs2D
        applyStimulus(0, 2'b01, 5, 3, 5, 0, 0, 0);
        #2;
        checkOutput("lit LU FEN dut0", int'(fen[0]), 0);
        checkOutput("lit LU RSTE dut0", int'(rste[0]), 1);
        idleCycles(1);
        #2;
        checkOutput("lit LU released dut0", int'(fen[0]), 1);
        checkOutput("lit LU bubble2 dut1", int'(fen[1]), 0);
        checkOutput("lit LU StallCount dut0", int'(scA), 1);
        idleCycles(2);
        #2;
        checkOutput("lit LU released dut1", int'(fen[1]), 1);
        checkOutput("lit LU StallCount dut1", int'(scB), 3);

        // Deeper bubbles via Rs1D, then x0 and non-load cases
        applyStimulus(0, 2'b01, 7, 7, 2, 0, 0, 0);
        idleCycles(3);
        #2;
        checkOutput("lit LU2 StallCount dut1", int'(scB), 6);
        checkOutput("lit LU2 StallCount dut0", int'(scA), 2);
        applyStimulus(0, 2'b01, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("lit x0 no stall dut1", int'(fen[1]), 1);
        checkOutput("lit x0 no RSTE dut1", int'(rste[1]), 0);
        applyStimulus(0, 2'b00, 6, 6, 6, 0, 0, 0);
        #2;
        checkOutput("lit non-load no stall dut1", int'(fen[1]), 1);

        // Miss freeze: pulse, four cycles waiting, then ReadyM
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0);
        #2;
        checkOutput("lit miss MEN dut0", int'(men[0]), 0);
        idleCycles(4);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("lit release FEN dut0", int'(fen[0]), 1);
        checkOutput("lit release Busy dut0", int'(busy[0]), 0);
        idleCycles(1);
        #2;
        checkOutput("lit miss StallCount dut0", int'(scA), 7);
        checkOutput("lit miss StallCount dut1", int'(scB), 11);
        checkOutput("lit miss TimeoutErr dut0", int'(terr[0]), 0);

        // Watchdog: ReadyM held low for 20 MISS cycles
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 20; i++) begin
            applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
            if (i == 7) begin
                #2;
                checkOutput("lit watchdog MISS7 dut0", int'(terr[0]), 0);
            end
            if (i == 8) begin
                #2;
                checkOutput("lit watchdog MISS8 dut0", int'(terr[0]), 1);
            end
        end
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1);
        idleCycles(1);
        #2;
        checkOutput("lit sticky TimeoutErr dut0", int'(terr[0]), 1);
        checkOutput("lit no TimeoutErr dut1", int'(terr[1]), 0);
        checkOutput("lit saturated StallCount dut0", int'(scA), 15);
        checkOutput("lit StallCount dut1", int'(scB), 32);

        // Load-use and miss together: freeze wins, stall follows release
        applyStimulus(0, 2'b01, 9, 9, 0, 0, 1, 0);
        #2;
        checkOutput("lit LU+miss RSTE dut1", int'(rste[1]), 0);
        checkOutput("lit LU+miss FEN dut1", int'(fen[1]), 0);
        applyStimulus(0, 2'b01, 9, 9, 0, 0, 0, 0);
        applyStimulus(0, 2'b01, 9, 9, 0, 0, 0, 0);
        applyStimulus(0, 2'b01, 9, 9, 0, 0, 0, 1);
        #2;
        checkOutput("lit post-release LU RSTE dut0", int'(rste[0]), 1);
        checkOutput("lit post-release MEN dut0", int'(men[0]), 1);
        idleCycles(3);

        // Pending bubbles are held across a freeze
        applyStimulus(0, 2'b01, 4, 0, 4, 0, 0, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("lit held bubble FEN dut1", int'(fen[1]), 0);
        checkOutput("lit held bubble FEN dut0", int'(fen[0]), 1);
        idleCycles(1);
        #2;
        checkOutput("lit last bubble FEN dut1", int'(fen[1]), 0);
        idleCycles(1);
        #2;
        checkOutput("lit bubbles done FEN dut1", int'(fen[1]), 1);

        // Branch flush during a countdown
        applyStimulus(0, 2'b01, 7, 7, 0, 0, 0, 0);
        idleCycles(1);
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 0, 0);
        #2;
        checkOutput("lit flush RSTD dut1", int'(rstd[1]), 1);
        checkOutput("lit flush FEN dut1", int'(fen[1]), 1);
        idleCycles(1);
        #2;
        checkOutput("lit after flush RSTE dut1", int'(rste[1]), 0);

        // Branch during freeze ignored, honoured in release cycle
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 1, 0);
        #2;
        checkOutput("lit frozen branch RSTD dut0", int'(rstd[0]), 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 1, 0, 1);
        #2;
        checkOutput("lit release branch RSTD dut0", int'(rstd[0]), 1);

        // MissM with ReadyM in IDLE, then MissM in the release cycle
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 1);
        #2;
        checkOutput("lit miss+ready FEN dut0", int'(fen[0]), 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 1);
        #2;
        checkOutput("lit release ignores MissM dut0", int'(fen[0]), 1);
        idleCycles(1);
        #2;
        checkOutput("lit no new miss dut0", int'(fen[0]), 1);

        // Reset in the second MISS cycle, and mid-countdown
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 2'b00, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("lit rst forces MEN dut0", int'(men[0]), 1);
        checkOutput("lit rst forces Busy dut0", int'(busy[0]), 0);
        idleCycles(1);
        #2;
        checkOutput("lit after rst FEN dut0", int'(fen[0]), 1);
        checkOutput("lit after rst TimeoutErr dut0", int'(terr[0]), 0);
        checkOutput("lit after rst StallCount dut0", int'(scA), 0);
        applyStimulus(0, 2'b01, 3, 3, 3, 0, 0, 0);
        applyStimulus(1, 2'b00, 0, 0, 0, 0, 0, 0);
        idleCycles(1);
        #2;
        checkOutput("lit rst abandons countdown dut1", int'(fen[1]), 1);
        idleCycles(2);

        checkEn = 1'b0;
        @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
